// File: rtl/display_loader.sv
// display_loader: serially loads NUM_DIGITS 5-bit codes into a multiplexed
// display through its digit/latch interface. The display captures on the latch
// falling edge; the first code shifted ends up at the highest position.
//
// Build option: define DISPLAY_LOADER_LEADING_BLANK_EN to replace a zero code
// at the highest position with BLANK_CODE when the snapshot is taken.
//
// state | meaning
// IDLE  | waiting for start or a pending request
// SETUP | digit_out presented, latch low
// HIGH  | latch high, digit_out stable
// HOLD  | latch low (capture edge on entry), digit_out held
// DONE  | one-cycle done pulse, busy low
module display_loader #(
  parameter int         NUM_DIGITS = 6,
  parameter int         SETUP_CYC  = 1,
  parameter int         HIGH_CYC   = 2,
  parameter int         HOLD_CYC   = 1,
  parameter logic [4:0] BLANK_CODE = 5'd31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  output logic [4:0]              digit_out,
  output logic                    latch_out,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int MAX_CYC = (MAX_SH > HOLD_CYC) ? MAX_SH : HOLD_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

`ifdef DISPLAY_LOADER_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_snap    [NUM_DIGITS];
  logic [4:0]        w_snap_in [NUM_DIGITS];
  logic [2:0]        r_index;
  logic [PH_W-1:0]   r_phase;
  logic              r_pending;
  logic [4:0]        r_digit;
  logic              w_launch;
  logic              w_phase_tc;
  logic              w_step_digit;

  // Unpack the incoming word, optionally blanking a leading zero.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_snap_in[k] = digits_in[5*k +: 5];
    end
    if (BLANK_EN && (w_snap_in[NUM_DIGITS-1] == 5'd0)) begin
      w_snap_in[NUM_DIGITS-1] = BLANK_CODE;
    end
  end

  // Next-state decode; each timed phase ends on the counter's terminal count.
  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_phase_tc   = (r_phase == '0);
    w_step_digit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_pending) begin
          w_launch    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: if (w_phase_tc) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_phase_tc) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_phase_tc) begin
          if (r_index == 3'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt  = S_SETUP;
            w_step_digit = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Phase timer, digit index, pending request and presented digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index   <= LAST_IDX;
      r_phase   <= '0;
      r_pending <= 1'b0;
      r_digit   <= 5'd0;
    end else begin
      if (w_launch)
        r_pending <= 1'b0;
      else if (start && (r_state != S_IDLE))
        r_pending <= 1'b1;

      if (r_state != w_state_nxt) begin
        case (w_state_nxt)
          S_SETUP: r_phase <= PH_W'(SETUP_CYC - 1);
          S_HIGH:  r_phase <= PH_W'(HIGH_CYC - 1);
          S_HOLD:  r_phase <= PH_W'(HOLD_CYC - 1);
          default: r_phase <= '0;
        endcase
      end else if (!w_phase_tc) begin
        r_phase <= r_phase - 1'b1;
      end

      if (w_launch) begin
        r_index <= LAST_IDX;
        r_digit <= w_snap_in[NUM_DIGITS-1];
      end else if (w_step_digit) begin
        r_index <= r_index - 3'd1;
        r_digit <= r_snap[r_index - 3'd1];
      end
    end
  end

  // Snapshot is taken only at launch so input changes mid-load are ignored.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_snap[k] <= w_snap_in[k];
      end
    end
  end

  assign digit_out = r_digit;
  assign latch_out = (r_state == S_HIGH);
  assign busy      = (r_state == S_SETUP) || (r_state == S_HIGH) || (r_state == S_HOLD);
  assign done      = (r_state == S_DONE);

endmodule
